// File: rtl/bicubic_stream_ctrl.sv
// Frame sequencer for the bicubic path: accepts one padded frame, tags each pixel
// with its position and window flags, and drives the rotating line-buffer write port.
module bicubic_stream_ctrl #(
    parameter int WIDTH  = 960,
    parameter int HEIGHT = 540,
    parameter int PAD    = 3,
    parameter int CW     = 10,
    parameter int RW     = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    input  logic [23:0]   in_data,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [23:0]   out_data,
    output logic [CW-1:0] out_col,
    output logic [RW-1:0] out_row,
    output logic          out_win,
    output logic          out_sof,
    output logic          out_eol,
    output logic          out_eof,
    output logic          lb_wr_en,
    output logic [1:0]    lb_wr_sel,
    output logic [CW-1:0] lb_wr_addr,
    output logic [23:0]   lb_wr_data,
    output logic          busy,
    output logic          done
);
    localparam int PW = WIDTH + PAD;
    localparam int PH = HEIGHT + PAD;
    localparam logic [CW-1:0] COL_LAST = CW'(PW - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(PH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            out_valid_q, out_valid_d;
    logic [23:0]     out_data_q, out_data_d;
    logic [CW-1:0]   out_col_q, out_col_d;
    logic [RW-1:0]   out_row_q, out_row_d;
    logic            out_win_q, out_win_d;
    logic            out_sof_q, out_sof_d;
    logic            out_eol_q, out_eol_d;
    logic            out_eof_q, out_eof_d;
    logic            lb_wr_en_q, lb_wr_en_d;
    logic [1:0]      lb_wr_sel_q, lb_wr_sel_d;
    logic [CW-1:0]   lb_wr_addr_q, lb_wr_addr_d;
    logic [23:0]     lb_wr_data_q, lb_wr_data_d;

    logic in_ready_s;
    logic accept_s;
    logic col_last_s;
    logic row_last_s;

    // in_ready must fall in the same cycle as a stalled output, so it stays combinational
    assign in_ready_s = (state_q == ST_RUN) & (~out_valid_q | out_ready);
    assign accept_s   = in_valid & in_ready_s;
    assign col_last_s = (col_q == COL_LAST);
    assign row_last_s = (row_q == ROW_LAST);

    // Next state, position counters and status flags
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    col_d   = {CW{1'b0}};
                    row_d   = {RW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s) begin
                    if (col_last_s) begin
                        col_d = {CW{1'b0}};
                        row_d = row_last_s ? {RW{1'b0}} : (row_q + RW'(1));
                    end else begin
                        col_d = col_q + CW'(1);
                        row_d = row_q;
                    end
                    state_d = (col_last_s && row_last_s) ? ST_DRAIN : ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (out_valid_q && out_ready) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // Output slice and line-buffer write capture
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_col_d    = out_col_q;
        out_row_d    = out_row_q;
        out_win_d    = out_win_q;
        out_sof_d    = out_sof_q;
        out_eol_d    = out_eol_q;
        out_eof_d    = out_eof_q;
        lb_wr_en_d   = 1'b0;
        lb_wr_sel_d  = lb_wr_sel_q;
        lb_wr_addr_d = lb_wr_addr_q;
        lb_wr_data_d = lb_wr_data_q;
        if (accept_s) begin
            out_valid_d  = 1'b1;
            out_data_d   = in_data;
            out_col_d    = col_q;
            out_row_d    = row_q;
            out_win_d    = (row_q >= RW'(3)) && (col_q >= CW'(3));
            out_sof_d    = (col_q == {CW{1'b0}}) && (row_q == {RW{1'b0}});
            out_eol_d    = col_last_s;
            out_eof_d    = col_last_s && row_last_s;
            lb_wr_en_d   = 1'b1;
            lb_wr_sel_d  = row_q[1:0];
            lb_wr_addr_d = col_q;
            lb_wr_data_d = in_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            col_q   <= {CW{1'b0}};
            row_q   <= {RW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= 24'd0;
            out_col_q    <= {CW{1'b0}};
            out_row_q    <= {RW{1'b0}};
            out_win_q    <= 1'b0;
            out_sof_q    <= 1'b0;
            out_eol_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            lb_wr_en_q   <= 1'b0;
            lb_wr_sel_q  <= 2'd0;
            lb_wr_addr_q <= {CW{1'b0}};
            lb_wr_data_q <= 24'd0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_col_q    <= out_col_d;
            out_row_q    <= out_row_d;
            out_win_q    <= out_win_d;
            out_sof_q    <= out_sof_d;
            out_eol_q    <= out_eol_d;
            out_eof_q    <= out_eof_d;
            lb_wr_en_q   <= lb_wr_en_d;
            lb_wr_sel_q  <= lb_wr_sel_d;
            lb_wr_addr_q <= lb_wr_addr_d;
            lb_wr_data_q <= lb_wr_data_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_col    = out_col_q;
    assign out_row    = out_row_q;
    assign out_win    = out_win_q;
    assign out_sof    = out_sof_q;
    assign out_eol    = out_eol_q;
    assign out_eof    = out_eof_q;
    assign lb_wr_en   = lb_wr_en_q;
    assign lb_wr_sel  = lb_wr_sel_q;
    assign lb_wr_addr = lb_wr_addr_q;
    assign lb_wr_data = lb_wr_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule
